add_share_arbiter: RTL and testbench
====================================

// Module: add_share_arbiter
// PURPOSE
//   Shares one WIDTH-bit `add` instance among NUM_REQ requesters.
//   Round-robin arbitration with valid/ready on both request and response sides.
//   One operation in flight at a time; the adder is driven from registered operands.
//   Sits between the requester blocks and the `add` datapath inside the DUT that the
//   simulation harness drives.
// PARAMETERS
//   NUM_REQ      4   number of requesters, 2..8
//   WIDTH        16  operand/result width; must match the `add` instance
//   ADD_LATENCY  1   clocks from operands stable to add_result valid, >=1
// PORTS
//   clk         in   1              single clock, rising edge
//   rst         in   1              asynchronous, active-low reset
//   req_valid   in   NUM_REQ        per-requester request valid
//   req_ready   out  NUM_REQ        per-requester accept, one-hot or zero
//   req_a       in   NUM_REQ*WIDTH  operand a; requester i uses bits [i*WIDTH +: WIDTH]
//   req_b       in   NUM_REQ*WIDTH  operand b, same packing as req_a
//   rsp_valid   out  NUM_REQ        per-requester result valid, one-hot or zero
//   rsp_ready   in   NUM_REQ        per-requester result accept
//   rsp_result  out  WIDTH          shared result bus, qualified by rsp_valid
//   add_a       out  WIDTH          to add.a
//   add_b       out  WIDTH          to add.b
//   add_result  in   WIDTH          from add.result
//   ops_done    out  32             completed-operation count, wraps at 2^32
// BEHAVIOUR
//   Reset (rst=0, asynchronous)
//     - state=IDLE; rr_ptr=0; cnt=0; grant=0.
//     - op_a, op_b, add_a, add_b, rsp_result and ops_done clear to 0.
//     - req_ready and rsp_valid clear to all 0.
//     - Reset mid-operation discards the in-flight op; no response is ever issued for it.
//   FSM: IDLE -> WAIT -> RESP -> IDLE
//   IDLE
//     - grant g = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     - req_ready[g]=1 combinationally in the same cycle; req_ready is 0 in every other state.
//     - At the edge: op_a/op_b <= req_a/req_b slice g; cnt <= ADD_LATENCY;
//       rr_ptr <= (g+1) mod NUM_REQ; go to WAIT.
//     - No req_valid: stay in IDLE; rr_ptr unchanged.
//   WAIT
//     - add_a=op_a and add_b=op_b, held stable.
//     - cnt decrements each clock.
//     - On the edge where cnt==1: rsp_result <= add_result; go to RESP.
//   RESP
//     - rsp_valid[g]=1 (registered); rsp_result held.
//     - Leave when rsp_ready[g]=1: go to IDLE; ops_done += 1.
//     - rsp_ready of other requesters is ignored.
//     - No new grant while in RESP.
//   Timing
//     - Accept edge to rsp_valid high: ADD_LATENCY clocks.
//     - Minimum spacing between two accepts: ADD_LATENCY+2 clocks (one IDLE bubble).
//   Arithmetic: add_result is taken as-is (mod 2^WIDTH); no carry out.
//   Requester rules
//     - Once req_valid[i] is high, hold req_valid[i] and operands stable until req_ready[i].
//     - Dropping req_valid[i] before grant is legal; it causes no grant.
//   rsp_ready held low indefinitely: stay in RESP with rsp_valid and rsp_result stable.
//   add_a and add_b keep their last value outside WAIT.
// TESTING
//   1. Reset: rst=0 during traffic -> req_ready=0, rsp_valid=0, add_a=add_b=0, ops_done=0.
//      After release, the first grant goes to req 0.
//   2. Single request: req_valid[1], a=3, b=4 -> req_ready[1] for 1 cycle.
//      rsp_valid[1] high 1 clk later with rsp_result=7; ops_done=1.
//   3. Wrap: a=16'hFFFF, b=16'h0002 -> rsp_result=16'h0001.
//   4. Fairness: all 4 req_valid held high, rsp_ready=1 ->
//      grant order 0,1,2,3,0,1, each accept 3 clocks apart.
//   5. Backpressure: rsp_ready[2]=0 for 5 clks -> rsp_valid[2] and rsp_result stable,
//      req_ready all 0. Raise rsp_ready -> next grant 2 clks later.
//   6. Reset in WAIT: rst pulse -> no rsp_valid for the dropped op.
//      Re-request with a=10, b=20 -> rsp_result=30.

Source files
------------

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NUM_REQ requesters.
// One operation in flight; the adder is fed from registered operands.
module add_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 16,
    parameter int ADD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_result,
    output logic [31:0]              ops_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ADD_LATENCY + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic             grant_any;
    logic [IDX_W-1:0] grant_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Rotating priority scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!grant_any && req_valid[j]) begin
                grant_any = 1'b1;
                grant_idx = j[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // req_ready is gated by reset so no requester sees an accept while held in reset.
    always_comb begin
        req_ready = '0;
        if (rst && state == IDLE && grant_any) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) rsp_valid[grant_q] = 1'b1;
    end

    // Operands only change at accept, so the adder inputs hold their last value.
    assign add_a = op_a;
    assign add_b = op_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_q    <= '0;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_result <= '0;
            ops_done   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        grant_q <= grant_idx;
                        cnt     <= CNT_W'(ADD_LATENCY);
                        rr_ptr  <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        rsp_result <= add_result;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_q]) begin
                        ops_done <= ops_done + 32'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them at each response handshake.
module tb_add_share_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_result;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic [W-1:0]   add_result;
    logic [31:0]    ops_done;

    add_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ADD_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .ops_done(ops_done)
    );

    // Single-cycle adder: result settles within the cycle the operands are stable.
    assign add_result = add_a + add_b;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [15:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [15:0] res);
        exp_t e;
        e.idx = idx;
        e.res = res;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b);
        req_valid[i]     = v;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    // Waits for a grant, checks it is exactly the expected one-hot, returns the accept edge number.
    task automatic wait_accept(input int exp_g, input string name, output int acc);
        bit seen;
        logic [N-1:0] exp_vec;
        seen = 1'b0;
        acc  = -1;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: no grant seen, expected req %0d", name, exp_g);
        end else begin
            exp_vec = '0;
            exp_vec[exp_g] = 1'b1;
            check(name, 32'(req_ready), 32'(exp_vec));
            acc = cyc + 1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: %0d responses never arrived", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: compares each response at its handshake.
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            int idx;
            idx = 0;
            for (int i = 0; i < N; i++) if (rsp_valid[i]) idx = i;
            if (!$onehot(rsp_valid)) begin
                total++;
                bad++;
                $display("FAIL rsp_onehot: got %b", rsp_valid);
            end else if (rsp_ready[idx]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: req %0d result %0h, none expected", idx, rsp_result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_idx", 32'(idx), 32'(e.idx));
                    check("rsp_result", 32'(rsp_result), 32'(e.res));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        int raised;
        int          f_idx[6];
        logic [15:0] f_a[6];
        logic [15:0] f_b[6];
        logic [15:0] f_r[6];
        bit          f_more[6];

        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_add_a", 32'(add_a), 32'h0);
        check("rst_add_b", 32'(add_b), 32'h0);
        check("rst_rsp_result", 32'(rsp_result), 32'h0);
        check("rst_ops_done", ops_done, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Fairness: all four requesters busy, grants rotate 0,1,2,3,0,1, three clocks apart.
        f_idx = '{0, 1, 2, 3, 0, 1};
        f_a   = '{16'h0010, 16'h0100, 16'h1000, 16'h8000, 16'h0005, 16'h00FF};
        f_b   = '{16'h0001, 16'h0002, 16'h0003, 16'h8000, 16'h0006, 16'h0001};
        f_r   = '{16'h0011, 16'h0102, 16'h1003, 16'h0000, 16'h000B, 16'h0100};
        f_more = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) set_req(f_idx[k], 1'b1, f_a[k], f_b[k]);
        for (int k = 0; k < 6; k++) push_exp(f_idx[k], f_r[k]);
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_accept(f_idx[k], "fair_grant", acc);
            if (k > 0) check("fair_spacing", 32'(acc - prev), 32'd3);
            prev = acc;
            if (f_more[k]) set_req(f_idx[k], 1'b1, f_a[k+4], f_b[k+4]);
            else           set_req(f_idx[k], 1'b0, 16'h0, 16'h0);
        end
        wait_drain("fair_drain");
        check("fair_ops_done", ops_done, 32'd6);

        // Single request 3+4 from req 1
        set_req(1, 1'b1, 16'd3, 16'd4);
        push_exp(1, 16'd7);
        wait_accept(1, "single_grant", acc);
        set_req(1, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check("single_ready_1cyc", 32'(req_ready), 32'h0);
        check("single_no_rsp_yet", 32'(rsp_valid), 32'h0);
        check("single_add_a", 32'(add_a), 32'd3);
        check("single_add_b", 32'(add_b), 32'd4);
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp_valid), 32'b0010);
        wait_drain("single_drain");
        check("single_ops_done", ops_done, 32'd7);

        // Wrap: FFFF + 0002 = 0001
        set_req(2, 1'b1, 16'hFFFF, 16'h0002);
        push_exp(2, 16'h0001);
        wait_accept(2, "wrap_grant", acc);
        set_req(2, 1'b0, 16'h0, 16'h0);
        wait_drain("wrap_drain");
        check("wrap_ops_done", ops_done, 32'd8);

        // Backpressure on req 2 while req 0 waits
        rsp_ready = 4'b1011;
        set_req(2, 1'b1, 16'h1234, 16'h4321);
        push_exp(2, 16'h5555);
        wait_accept(2, "bp_grant", acc);
        set_req(2, 1'b0, 16'h0, 16'h0);
        set_req(0, 1'b1, 16'h0007, 16'h0009);
        push_exp(0, 16'h0010);
        for (int n = 0; n < 20 && rsp_valid == '0; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'b0100);
            check("bp_rsp_result", 32'(rsp_result), 32'h5555);
            check("bp_req_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        raised = cyc;
        rsp_ready = '1;
        wait_accept(0, "bp_next_grant", acc);
        check("bp_next_grant_delay", 32'(acc - raised), 32'd2);
        set_req(0, 1'b0, 16'h0, 16'h0);
        wait_drain("bp_drain");
        check("bp_ops_done", ops_done, 32'd10);

        // Reset while an op from req 1 is in WAIT; it must never respond.
        set_req(0, 1'b1, 16'd10, 16'd20);
        set_req(1, 1'b1, 16'h0AAA, 16'h0555);
        set_req(2, 1'b1, 16'h0001, 16'h0001);
        set_req(3, 1'b1, 16'h0002, 16'h0002);
        wait_accept(1, "mid_rst_grant", acc);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 32'h0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_add_a", 32'(add_a), 32'h0);
        check("mid_rst_add_b", 32'(add_b), 32'h0);
        check("mid_rst_ops_done", ops_done, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_exp(0, 16'd30);
        wait_accept(0, "post_rst_grant", acc);
        req_valid = '0;
        wait_drain("post_rst_drain");
        check("post_rst_ops_done", ops_done, 32'd1);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
